hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Owns PC write enable, IF_ID stall/flush,
//  ID_EX bubble and the back-end freeze (ID_EX, EX_MEM, MEM_WB hold). Resolves load-use hazards,
//  taken-branch flushes and multi-cycle data-memory stalls. Flags a memory-stall timeout and keeps
//  saturating stall/flush performance counters.
// PARAMETERS
//  RA_W        5    register-index width
//  CNT_W       32   performance counter width
//  MEM_TIMEOUT 255  consecutive mem_stall_i cycles before FAULT (>=1, fits in 16 bits)
// PORTS
//  clk_i              in   1      clock; all state updates on posedge
//  rst_i              in   1      synchronous active-low reset
//  id_rs1_i           in   RA_W   ID-stage source register 1
//  id_rs2_i           in   RA_W   ID-stage source register 2
//  id_use_rs1_i       in   1      ID instruction reads rs1
//  id_use_rs2_i       in   1      ID instruction reads rs2
//  ex_rd_i            in   RA_W   EX-stage destination register
//  ex_memread_i       in   1      EX instruction is a load
//  id_br_taken_i      in   1      branch/jump resolved taken in ID
//  mem_stall_i        in   1      data memory not ready this cycle
//  pc_write_o         out  1      PC update enable
//  if_id_stall_o      out  1      hold IF_ID
//  if_id_flush_o      out  1      zero IF_ID (NOP)
//  id_ex_bubble_o     out  1      load a bubble into ID_EX
//  be_freeze_o        out  1      hold ID_EX, EX_MEM, MEM_WB
//  timeout_o          out  1      sticky memory-stall timeout
//  stall_cnt_o        out  CNT_W  cycles with pc_write_o=0 (saturating)
//  flush_cnt_o        out  CNT_W  cycles with if_id_flush_o=1 (saturating)
// BEHAVIOUR
//  - Controls are combinational from state + inputs (same-cycle). rst_i=0 at posedge -> state RUN,
//    wait counter 0, timeout_o 0, both counters 0. While rst_i=0: pc_write_o=0, other controls 0.
//  - lu = ex_memread_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
//  - Evaluation in RUN, or MEM_WAIT with mem_stall_i=0 (priority order):
//     1 mem_stall_i: pc_write=0, if_id_stall=1, be_freeze=1; next MEM_WAIT, wait_cnt<=1.
//     2 lu: pc_write=0, if_id_stall=1, id_ex_bubble=1; branch ignored this cycle (re-resolved next).
//     3 id_br_taken_i: pc_write=1, if_id_flush=1.
//     4 else pc_write=1, all others 0. Next RUN.
//  - MEM_WAIT with mem_stall_i=1: freeze as rule 1, wait_cnt++; when wait_cnt==MEM_TIMEOUT -> FAULT.
//    Release cycle (mem_stall_i=0) evaluates rules 2-4 at once: zero extra penalty cycles.
//  - FAULT: pc_write=0, if_id_stall=1, be_freeze=1, timeout_o=1; exits only via reset.
//  - Flush and stall never both asserted; bubble never with freeze.
//  - Counters increment by 1 per qualifying cycle, hold at all-ones; not updated while rst_i=0.
//  - Reset mid-MEM_WAIT/FAULT: next cycle RUN, controls per rules on the following cycle.
// STRUCTURE
//  - Shared header hazard_ctrl_defs.vh: state encodings ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_FAULT=2'd2.
//  - Sub-module sat_counter (WIDTH param, en, sync active-low clear) instanced twice for perf counters.
//  - wait counter: 16-bit local register.
// TESTING
//  1 lw x5 in EX, ID add x6,x5,x1 (use_rs1) -> one cycle pc_write=0, if_id_stall=1, bubble=1; next cycle clear.
//  2 ex_rd=0 with memread, rs1=0 -> no stall; ex_rd=5 but use_rs1=0,use_rs2=0 -> no stall.
//  3 id_br_taken_i=1 for 1 cycle -> if_id_flush=1, pc_write=1; flush_cnt 0->1.
//  4 mem_stall_i high 3 cycles while br_taken=1 -> 3 freeze cycles, flush on 4th cycle; stall_cnt=3.
//  5 MEM_TIMEOUT=4, mem_stall_i held -> timeout_o=1 after 4th MEM_WAIT cycle, stays frozen after
//    mem_stall_i drops; rst_i=0 one cycle -> RUN, timeout_o=0, counters 0.
//  6 CNT_W=3, 9 stall cycles -> stall_cnt_o saturates at 7.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer state encoding
// and the bundle of per-cycle pipeline control strobes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  localparam int WAIT_W = 16;

  typedef struct packed {
    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic be_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE   = '0;
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, be_freeze: 1'b1};
  localparam ctrl_t CTRL_LU     = '{pc_write: 1'b0, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b1, be_freeze: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b0, be_freeze: 1'b0};
  localparam ctrl_t CTRL_ADV    = '{pc_write: 1'b1, if_id_stall: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, be_freeze: 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module hazard_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// data-memory freezes with a sticky timeout, and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W        = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [RA_W-1:0]  ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             id_br_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             be_freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output state_t           dbg_state_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  ctrl_t             w_ctrl;
  logic              w_lu;

  assign w_lu = ex_memread_i && (ex_rd_i != '0) &&
                ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // wait count includes the RUN cycle that first saw the stall
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (!mem_stall_i) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else if (r_state == ST_RUN) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end else if (r_wait_cnt >= TIMEOUT) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_NONE;
    if (rst_i) begin
      if ((r_state == ST_FAULT) || mem_stall_i) w_ctrl = CTRL_FREEZE;
      else if (w_lu)                            w_ctrl = CTRL_LU;
      else if (id_br_taken_i)                   w_ctrl = CTRL_FLUSH;
      else                                      w_ctrl = CTRL_ADV;
    end
  end

  assign pc_write_o     = w_ctrl.pc_write;
  assign if_id_stall_o  = w_ctrl.if_id_stall;
  assign if_id_flush_o  = w_ctrl.if_id_flush;
  assign id_ex_bubble_o = w_ctrl.id_ex_bubble;
  assign be_freeze_o    = w_ctrl.be_freeze;
  assign timeout_o      = (r_state == ST_FAULT);
  assign dbg_state_o    = r_state;

  hazard_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (!w_ctrl.pc_write),
    .count_o (stall_cnt_o)
  );

  hazard_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (w_ctrl.if_id_flush),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios then random traffic, checked
// against a cycle-level reference model through an expected-value queue.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int RA_W        = 5;
  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int EW          = 6 + 2 * CNT_W;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_i;
  logic [RA_W-1:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic             id_use_rs1_i, id_use_rs2_i, ex_memread_i, id_br_taken_i, mem_stall_i;
  logic             pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, be_freeze_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  state_t           dbg_state_o;

  hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_use_rs1_i   (id_use_rs1_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .ex_rd_i        (ex_rd_i),
    .ex_memread_i   (ex_memread_i),
    .id_br_taken_i  (id_br_taken_i),
    .mem_stall_i    (mem_stall_i),
    .pc_write_o     (pc_write_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .be_freeze_o    (be_freeze_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_err;
  int cyc;

  // reference model: fault latch, length of the current run of stall cycles, counters
  bit m_fault;
  int m_stall_run;
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic drive(input bit rst, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int exrd, input bit mr, input bit br, input bit ms);
    bit pc, st, fl, bb, fz, lu;
    @(negedge clk);
    rst_i         = rst;
    id_rs1_i      = RA_W'(rs1);
    id_rs2_i      = RA_W'(rs2);
    id_use_rs1_i  = u1;
    id_use_rs2_i  = u2;
    ex_rd_i       = RA_W'(exrd);
    ex_memread_i  = mr;
    id_br_taken_i = br;
    mem_stall_i   = ms;
    lu = mr && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
    {pc, st, fl, bb, fz} = 5'b0;
    if (rst) begin
      if (m_fault || ms) begin st = 1; fz = 1; end
      else if (lu)       begin st = 1; bb = 1; end
      else if (br)       begin pc = 1; fl = 1; end
      else               pc = 1;
    end
    exp_q.push_back({pc, st, fl, bb, fz, m_fault, CNT_W'(m_stall_cnt), CNT_W'(m_flush_cnt)});
    if (!rst) begin
      m_fault = 0; m_stall_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!pc && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (fl && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (!m_fault) begin
        if (ms) begin
          m_stall_run++;
          if (m_stall_run > MEM_TIMEOUT) m_fault = 1;
        end else begin
          m_stall_run = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // scoreboard monitor: compares each cycle's outputs well after the inputs settle
  initial begin
    logic [EW-1:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        got_v = {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, be_freeze_o,
                 timeout_o, stall_cnt_o, flush_cnt_o};
        n_vec++;
        if (got_v !== exp_v) begin
          n_err++;
          $display("FAIL ctrl_vec cycle %0d: got pc/st/fl/bb/fz/to=%b stall_cnt=%0d flush_cnt=%0d, expected %b stall_cnt=%0d flush_cnt=%0d",
                   cyc, got_v[EW-1 -: 6], got_v[2*CNT_W-1 -: CNT_W], got_v[CNT_W-1:0],
                   exp_v[EW-1 -: 6], exp_v[2*CNT_W-1 -: CNT_W], exp_v[CNT_W-1:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    n_vec = 0; n_err = 0; cyc = 0;
    m_fault = 0; m_stall_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    rst_i = 1'b0;
    {id_rs1_i, id_rs2_i, ex_rd_i} = '0;
    {id_use_rs1_i, id_use_rs2_i, ex_memread_i, id_br_taken_i, mem_stall_i} = '0;
    repeat (2) @(posedge clk);

    do_reset();
    do_reset();
    idle(1);
    // load-use on rs1, then the bubble has moved on
    drive(1, 5, 1, 1, 1, 5, 1, 0, 0);
    drive(1, 5, 1, 1, 1, 0, 0, 0, 0);
    // load-use on rs2 with a taken branch ignored this cycle
    drive(1, 2, 7, 1, 1, 7, 1, 1, 0);
    // no hazard: load to x0, and unused operands
    drive(1, 0, 0, 1, 1, 0, 1, 0, 0);
    drive(1, 5, 5, 0, 0, 5, 1, 0, 0);
    // single taken branch
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // memory stall under a taken branch, flush on release
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0 == 1 ? 0 : 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // timeout and sticky freeze, cleared by reset
    do_reset();
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 3, 0, 1, 0, 0, 0, 1, 0);
    do_reset();
    idle(2);
    // stall counter saturation
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, 4, 0, 1, 0, 4, 1, 0, 0);
    idle(2);
    // random traffic with small register range to provoke collisions
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 29) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    idle(1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
